// File: rtl/vec_mem_arbiter.sv
// Shares the single memory port between the picorv32 core (CPU) and its vector
// coprocessor (VEC). One transaction is in flight at a time; a watchdog completes unanswered ones.
module vec_mem_arbiter #(
  parameter int VEC_BURST = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant_vec,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    VEC_BUSY = 2'd2
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(VEC_BURST);
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [7:0]  burst_cnt_r, burst_cnt_s;
  logic [7:0]  wd_cnt_r, wd_cnt_s;
  logic        mem_valid_r, mem_valid_s;
  logic        mem_instr_r, mem_instr_s;
  logic [31:0] mem_addr_r, mem_addr_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic [3:0]  mem_wstrb_r, mem_wstrb_s;
  logic        grant_vec_r, grant_vec_s;
  logic        timeout_err_r, timeout_err_s;
  logic        busy_s, wd_fire_s, done_s, vec_wins_s;

  // Arbitration, grant capture, watchdog and completion decode
  always_comb begin
    state_s       = state_r;
    burst_cnt_s   = burst_cnt_r;
    wd_cnt_s      = wd_cnt_r;
    mem_valid_s   = mem_valid_r;
    mem_instr_s   = mem_instr_r;
    mem_addr_s    = mem_addr_r;
    mem_wdata_s   = mem_wdata_r;
    mem_wstrb_s   = mem_wstrb_r;
    grant_vec_s   = grant_vec_r;
    timeout_err_s = timeout_err_r;
    busy_s        = (state_r == CPU_BUSY) || (state_r == VEC_BUSY);
    wd_fire_s     = busy_s && (wd_cnt_r == WD_LAST) && !mem_ready;
    done_s        = busy_s && (mem_ready || wd_fire_s);
    vec_wins_s    = vec_mem_valid && (!cpu_mem_valid || (burst_cnt_r < BURST_MAX));

    case (state_r)
      IDLE: begin
        if (vec_wins_s) begin
          state_s     = VEC_BUSY;
          mem_valid_s = 1'b1;
          grant_vec_s = 1'b1;
          mem_instr_s = 1'b0;
          mem_addr_s  = vec_mem_addr;
          mem_wdata_s = vec_mem_wdata;
          mem_wstrb_s = vec_mem_wstrb;
          wd_cnt_s    = 8'd0;
          // Under contention VEC only wins below BURST_MAX, so +1 never exceeds it;
          // a lone VEC request means nobody is waiting and the budget refills.
          if (cpu_mem_valid) begin
            burst_cnt_s = burst_cnt_r + 8'd1;
          end else begin
            burst_cnt_s = 8'd0;
          end
        end else if (cpu_mem_valid) begin
          state_s     = CPU_BUSY;
          mem_valid_s = 1'b1;
          grant_vec_s = 1'b0;
          mem_instr_s = cpu_mem_instr;
          mem_addr_s  = cpu_mem_addr;
          mem_wdata_s = cpu_mem_wdata;
          mem_wstrb_s = cpu_mem_wstrb;
          wd_cnt_s    = 8'd0;
          burst_cnt_s = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      CPU_BUSY, VEC_BUSY: begin
        if (done_s) begin
          state_s     = IDLE;
          mem_valid_s = 1'b0;
          grant_vec_s = 1'b0;
          // A real acknowledge in the watchdog cycle wins, so no error is flagged.
          if (wd_fire_s) begin
            timeout_err_s = 1'b1;
          end else begin
            timeout_err_s = timeout_err_r;
          end
        end else begin
          wd_cnt_s = wd_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s     = IDLE;
        mem_valid_s = 1'b0;
        grant_vec_s = 1'b0;
      end
    endcase
  end

  // Completion steering: only the owner sees ready; a watchdog completion returns zero data
  always_comb begin
    cpu_mem_ready = 1'b0;
    vec_mem_ready = 1'b0;
    cpu_mem_rdata = mem_rdata;
    vec_mem_rdata = mem_rdata;
    if (state_r == CPU_BUSY) begin
      cpu_mem_ready = done_s;
      if (wd_fire_s) begin
        cpu_mem_rdata = 32'h0000_0000;
      end else begin
        cpu_mem_rdata = mem_rdata;
      end
    end else if (state_r == VEC_BUSY) begin
      vec_mem_ready = done_s;
      if (wd_fire_s) begin
        vec_mem_rdata = 32'h0000_0000;
      end else begin
        vec_mem_rdata = mem_rdata;
      end
    end else begin
      cpu_mem_ready = 1'b0;
      vec_mem_ready = 1'b0;
    end
  end

  // State and downstream request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      burst_cnt_r   <= 8'd0;
      wd_cnt_r      <= 8'd0;
      mem_valid_r   <= 1'b0;
      mem_instr_r   <= 1'b0;
      mem_addr_r    <= 32'h0000_0000;
      mem_wdata_r   <= 32'h0000_0000;
      mem_wstrb_r   <= 4'b0000;
      grant_vec_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      burst_cnt_r   <= burst_cnt_s;
      wd_cnt_r      <= wd_cnt_s;
      mem_valid_r   <= mem_valid_s;
      mem_instr_r   <= mem_instr_s;
      mem_addr_r    <= mem_addr_s;
      mem_wdata_r   <= mem_wdata_s;
      mem_wstrb_r   <= mem_wstrb_s;
      grant_vec_r   <= grant_vec_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign mem_valid   = mem_valid_r;
  assign mem_instr   = mem_instr_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_wstrb   = mem_wstrb_r;
  assign grant_vec   = grant_vec_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Randomized bench for vec_mem_arbiter: two requester agents, a one-cycle memory with a
// 2 KiB window, and a transaction-level model predicting grants, completions and data.
module tb_vec_mem_arbiter;

  localparam int VB        = 4;
  localparam int TO        = 16;
  localparam int MEM_WORDS = 512;
  localparam int M_IDLE = 0, M_GRANT = 1, M_BUSY = 2, M_DRAIN = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_valid, cpu_mem_instr, cpu_mem_ready;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        vec_mem_valid, vec_mem_ready;
  logic [31:0] vec_mem_addr, vec_mem_wdata, vec_mem_rdata;
  logic [3:0]  vec_mem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        grant_vec, timeout_err;

  vec_mem_arbiter #(.VEC_BURST(VB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
    .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr), .vec_mem_wdata(vec_mem_wdata),
    .vec_mem_wstrb(vec_mem_wstrb), .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_vec(grant_vec), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input int i);
    if (i == 100) return 32'h0403_0201;
    return 32'(i) * 32'h9E37_79B1;
  endfunction

  // Memory: acks one cycle after mem_valid, only below 2048; writes honour strobes
  logic [31:0] mem [0:MEM_WORDS-1];
  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= mem_init(i);
    end else begin
      mem_ready <= 1'b0;
      if (mem_valid && !mem_ready && mem_addr < 32'd2048) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr[10:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[10:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester agents and reference model state
  txn_t        cq[$], vq[$];
  txn_t        cur[2];
  bit          act[2];
  int          mst, k, owner, rburst;
  txn_t        otx;
  bit          exp_terr, rec;
  int          gseq[$];
  logic [31:0] shadow [0:MEM_WORDS-1];

  function automatic txn_t rand_txn(input bit is_cpu, input bit allow_oob);
    txn_t t;
    if (allow_oob && $urandom_range(15) == 0) t.addr = 32'd2048 + (32'($urandom_range(63)) << 2);
    else t.addr = 32'($urandom_range(111, 96)) << 2;
    t.wdata = $urandom;
    t.wstrb = ($urandom_range(1) == 1) ? 4'(($urandom_range(14)) + 1) : 4'b0000;
    t.instr = is_cpu ? 1'($urandom_range(1)) : 1'b0;
    return t;
  endfunction

  task automatic init_model();
    mst = M_IDLE; k = 0; owner = 0; rburst = 0; exp_terr = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    cq.delete(); vq.delete();
    for (int i = 0; i < MEM_WORDS; i++) shadow[i] = mem_init(i);
    cpu_mem_valid = 1'b0; cpu_mem_instr = 1'b0; cpu_mem_addr = 32'h0; cpu_mem_wdata = 32'h0;
    cpu_mem_wstrb = 4'b0000;
    vec_mem_valid = 1'b0; vec_mem_addr = 32'h0; vec_mem_wdata = 32'h0; vec_mem_wstrb = 4'b0000;
  endtask

  task automatic step();
    logic        cr, vr, fin, oob;
    logic [31:0] exp_rd;
    int          w;
    @(negedge clk);
    cr = cpu_mem_ready;
    vr = vec_mem_ready;
    if (mst == M_DRAIN) begin
      mst = M_IDLE;
    end else if (mst == M_GRANT) begin
      check_val("grant_valid", {31'h0, mem_valid}, 32'd1);
      check_val("grant_vec", {31'h0, grant_vec}, 32'(owner));
      check_val("grant_addr", mem_addr, otx.addr);
      check_val("grant_wdata", mem_wdata, otx.wdata);
      check_val("grant_wstrb", {28'h0, mem_wstrb}, {28'h0, otx.wstrb});
      check_val("grant_instr", {31'h0, mem_instr}, (owner == 1) ? 32'd0 : {31'h0, otx.instr});
      mst = M_BUSY; k = 0;
    end else if (mst == M_BUSY) begin
      k++;
    end
    if (mst == M_IDLE) begin
      check_val("idle_valid", {31'h0, mem_valid}, 32'd0);
      check_val("idle_ready", {30'h0, cr, vr}, 32'd0);
    end else if (mst == M_BUSY) begin
      oob = (otx.addr >= 32'd2048);
      fin = oob ? (k == TO - 1) : (k == 1);
      check_val("cpu_ready", {31'h0, cr}, {31'h0, fin && owner == 0});
      check_val("vec_ready", {31'h0, vr}, {31'h0, fin && owner == 1});
      if (fin) begin
        w = int'(otx.addr[10:2]);
        exp_rd = oob ? 32'h0 : shadow[w];
        if (oob || otx.wstrb == 4'b0000)
          check_val("rdata", (owner == 1) ? vec_mem_rdata : cpu_mem_rdata, exp_rd);
        check_val("timeout_err", {31'h0, timeout_err}, {31'h0, exp_terr});
        if (oob) exp_terr = 1'b1;
        else for (int b = 0; b < 4; b++)
          if (otx.wstrb[b]) shadow[w][8*b +: 8] = otx.wdata[8*b +: 8];
        mst = M_DRAIN;
      end
    end
    // Requesters drop valid on seeing ready and may present the next request at once
    if (act[0] && cr) begin act[0] = 1'b0; cpu_mem_valid = 1'b0; end
    if (act[1] && vr) begin act[1] = 1'b0; vec_mem_valid = 1'b0; end
    if (!act[0] && cq.size() > 0) begin
      cur[0] = cq.pop_front(); act[0] = 1'b1; cpu_mem_valid = 1'b1;
      cpu_mem_addr = cur[0].addr; cpu_mem_wdata = cur[0].wdata;
      cpu_mem_wstrb = cur[0].wstrb; cpu_mem_instr = cur[0].instr;
    end
    if (!act[1] && vq.size() > 0) begin
      cur[1] = vq.pop_front(); act[1] = 1'b1; vec_mem_valid = 1'b1;
      vec_mem_addr = cur[1].addr; vec_mem_wdata = cur[1].wdata; vec_mem_wstrb = cur[1].wstrb;
    end
    if (mst == M_IDLE && (act[0] || act[1])) begin
      if (act[1] && (!act[0] || rburst < VB)) begin
        owner = 1; otx = cur[1];
        rburst = act[0] ? rburst + 1 : 0;
      end else begin
        owner = 0; otx = cur[0]; rburst = 0;
      end
      mst = M_GRANT;
      if (rec) gseq.push_back(owner);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mst != M_IDLE || act[0] || act[1] || cq.size() > 0 || vq.size() > 0) && n < 400) begin
      step(); n++;
    end
    if (n >= 400) check_val("idle_budget", 32'(n), 32'd0);
  endtask

  task automatic run_random(input int n, input int pc, input int pv);
    for (int i = 0; i < n; i++) begin
      if (cq.size() == 0 && $urandom_range(99) < pc) cq.push_back(rand_txn(1'b1, 1'b1));
      if (vq.size() == 0 && $urandom_range(99) < pv) vq.push_back(rand_txn(1'b0, 1'b1));
      step();
    end
  endtask

  initial begin
    logic [9:0] gpat;
    int         n;
    txn_t       t;
    reset = 1'b1;
    rec = 1'b0;
    init_model();
    repeat (3) @(negedge clk);
    check_val("rst_valid", {31'h0, mem_valid}, 32'd0);
    check_val("rst_gvec", {31'h0, grant_vec}, 32'd0);
    check_val("rst_terr", {31'h0, timeout_err}, 32'd0);
    check_val("rst_ready", {30'h0, cpu_mem_ready, vec_mem_ready}, 32'd0);
    check_val("rst_fields", mem_addr | mem_wdata | {27'h0, mem_wstrb, mem_instr}, 32'd0);
    reset = 1'b0;

    // CPU-only read of word 100, then VEC-only halfword write to word 200
    t = '{addr: 32'd400, wdata: 32'h0, wstrb: 4'b0000, instr: 1'b1};
    cq.push_back(t);
    wait_idle();
    t = '{addr: 32'd800, wdata: 32'h0000_0104, wstrb: 4'b0011, instr: 1'b0};
    vq.push_back(t);
    wait_idle();
    check_val("mem200_lo", {16'h0, mem[200][15:0]}, 32'h0000_0104);

    // Continuous contention: grant pattern follows the burst budget
    rec = 1'b1;
    gseq.delete();
    for (int i = 0; i < 6; i++) cq.push_back(rand_txn(1'b1, 1'b0));
    for (int i = 0; i < 12; i++) vq.push_back(rand_txn(1'b0, 1'b0));
    wait_idle();
    rec = 1'b0;
    check_val("gseq_len", 32'(gseq.size()), 32'd18);
    gpat = 10'h0;
    for (int i = 0; i < 10 && i < gseq.size(); i++) gpat[9-i] = gseq[i][0];
    check_val("grant_order", {22'h0, gpat}, {22'h0, 10'b1111011110});

    // Watchdog on an unacknowledged CPU read, then a normal VEC read
    t = '{addr: 32'd2048, wdata: 32'h0, wstrb: 4'b0000, instr: 1'b0};
    cq.push_back(t);
    wait_idle();
    check_val("terr_set", {31'h0, timeout_err}, 32'd1);
    t = '{addr: 32'd400, wdata: 32'h0, wstrb: 4'b0000, instr: 1'b0};
    vq.push_back(t);
    wait_idle();
    check_val("terr_held", {31'h0, timeout_err}, 32'd1);

    run_random(3000, 45, 45);
    wait_idle();

    // Reset while a VEC transaction is in flight
    t = '{addr: 32'd404, wdata: 32'h0, wstrb: 4'b0000, instr: 1'b0};
    vq.push_back(t);
    n = 0;
    while (!(mst == M_BUSY && owner == 1) && n < 50) begin step(); n++; end
    check_val("reach_vec_busy", 32'(n < 50), 32'd1);
    reset = 1'b1;
    init_model();
    @(negedge clk);
    check_val("mid_rst_valid", {31'h0, mem_valid}, 32'd0);
    check_val("mid_rst_gvec", {31'h0, grant_vec}, 32'd0);
    check_val("mid_rst_terr", {31'h0, timeout_err}, 32'd0);
    reset = 1'b0;
    t = '{addr: 32'd400, wdata: 32'h0, wstrb: 4'b0000, instr: 1'b1};
    cq.push_back(t);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/vec_mem_arbiter.md
Name: vec_mem_arbiter

Overview:
- Shares the single unified memory port between the picorv32 native memory interface (CPU) and the picorv32_pcpi_vec memory interface (VEC).
- Replaces the two independent memory processes currently writing the same array; exactly one transaction is in flight at a time.
- Arbitration favours the vector unit, so strided vlse/vsse runs stream, with a bounded burst so CPU fetches are never starved.
- A watchdog completes transactions that the memory never acknowledges, such as out-of-range addresses.

Parameters:
- VEC_BURST, 4: max consecutive VEC grants won while CPU is also requesting; 0 = CPU wins every contention.
- TIMEOUT, 16: busy cycles without mem_ready before forced completion; range 2..255.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_mem_valid  in  1  CPU request; held until cpu_mem_ready
- cpu_mem_instr  in  1  CPU fetch flag
- cpu_mem_addr  in  32  CPU byte address
- cpu_mem_wdata  in  32  CPU write data
- cpu_mem_wstrb  in  4  CPU byte strobes; 0 = read
- cpu_mem_ready  out  1  one-cycle completion pulse to CPU
- cpu_mem_rdata  out  32  read data, valid with cpu_mem_ready
- vec_mem_valid, vec_mem_addr, vec_mem_wdata, vec_mem_wstrb  in  1/32/32/4  VEC request, same rules as CPU
- vec_mem_ready  out  1  one-cycle completion pulse to VEC
- vec_mem_rdata  out  32  read data, valid with vec_mem_ready
- mem_valid  out  1  downstream request, registered
- mem_instr  out  1  downstream fetch flag (0 for VEC)
- mem_addr, mem_wdata, mem_wstrb  out  32/32/4  downstream request fields, registered at grant
- mem_ready  in  1  downstream acknowledge
- mem_rdata  in  32  downstream read data
- grant_vec  out  1  1 while a VEC transaction is in flight
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, CPU_BUSY, VEC_BUSY.
- Reset values: state IDLE; mem_valid 0; mem_addr, mem_wdata, mem_wstrb, mem_instr 0; grant_vec 0; timeout_err 0; burst_cnt 0; wd_cnt 0; both ready outputs 0.

Arbitration (IDLE, evaluated at each edge):
- Only CPU requesting -> CPU_BUSY.
- Only VEC requesting -> VEC_BUSY.
- Both requesting -> VEC_BUSY if burst_cnt < VEC_BURST, else CPU_BUSY.
- Neither requesting -> stay in IDLE.

Grant edge:
- Latch the winner's addr, wdata and wstrb into the mem_* registers.
- mem_instr = cpu_mem_instr for a CPU grant, 0 for a VEC grant.
- Set mem_valid = 1; grant_vec = 1 for a VEC grant.
- wd_cnt = 0.

Burst counter:
- A VEC grant made while cpu_mem_valid = 1 increments burst_cnt, saturating at VEC_BURST.
- Any CPU grant clears burst_cnt.
- A VEC grant made while the CPU is idle clears burst_cnt.

Busy states:
- mem_valid and the mem_* fields are held stable.
- wd_cnt increments every cycle.
- The requester's inputs are not re-sampled; a requester dropping valid mid-transaction is a protocol violation and is ignored.

Completion when mem_ready = 1:
- The owner's ready = 1 in that same cycle, combinational.
- The owner's rdata = mem_rdata.
- Next edge: mem_valid = 0, grant_vec = 0, state IDLE.

Completion by watchdog:
- Triggers when wd_cnt = TIMEOUT-1 and mem_ready = 0.
- The owner's ready = 1 with rdata = 32'h0.
- timeout_err is set and stays 1 until reset.
- Next edge: mem_valid = 0, state IDLE.
- mem_ready and timeout in the same cycle: the completion is a normal one; timeout_err is not set.

Latency and spacing:
- Request seen at edge N -> mem_valid high from N+1.
- With a one-cycle memory, the requester ready pulse occurs in cycle N+2.
- One IDLE cycle always separates transactions; requesters deassert valid on the edge where they see ready, so no duplicate grant occurs.

Non-owner outputs:
- The non-owner's ready is always 0.
- The non-owner's rdata is driven with mem_rdata; it carries no meaning.

Reset:
- Reset asserted mid-transaction returns everything to reset values at the next edge.
- An in-flight request is silently abandoned; requesters are reset alongside.

Test Plan:
- CPU-only read: cpu_mem_addr=400, memory[100]=32'h04030201 -> mem_valid from the cycle after the request; cpu_mem_ready pulse one cycle later with rdata 32'h04030201; vec_mem_ready stays 0.
- VEC-only write: vec addr 800, wdata 32'h00000104, wstrb 4'b0011 -> mem_wstrb=4'b0011, mem_instr=0, grant_vec=1 during the transaction; memory[200][15:0]=16'h0104 afterwards.
- Contention, VEC_BURST=4: both request continuously -> grant order V,V,V,V,C,V,V,V,V,C; burst_cnt clears after each CPU grant.
- Contention, VEC_BURST=0: both request -> CPU granted every contention; VEC granted only in IDLE cycles where the CPU is not requesting.
- Watchdog: CPU addr 2048 with the memory never acking, TIMEOUT=16 -> cpu_mem_ready pulse 16 cycles after grant with rdata 0; timeout_err=1 and held; the next VEC request is served normally.
- Reset mid-op: assert reset while VEC_BUSY -> next edge mem_valid=0, grant_vec=0, timeout_err=0, burst_cnt=0; a fresh CPU request after release is granted with normal latency.
